// File: rtl/seq_assert_pkg.sv
// Shared types and helpers for the sequential assertion checker.
// popcount/sat_add work on POP_W-bit operands; callers zero-extend and truncate.
package seq_assert_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} chan_state_t;

   localparam int POP_W = 64;

   function automatic logic [POP_W-1:0] popcount(input logic [POP_W-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_W; i++) n = n + {{(POP_W-1){1'b0}}, v[i]};
      return n;
   endfunction

   // Sum of a and b clamped to 2^w-1, w <= POP_W.
   function automatic logic [POP_W-1:0] sat_add(input logic [POP_W-1:0] a,
                                                input logic [POP_W-1:0] b,
                                                input int w);
      logic [POP_W:0] sum;
      logic [POP_W:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = ((POP_W+1)'(1) << w) - (POP_W+1)'(1);
      return (sum > lim) ? lim[POP_W-1:0] : sum[POP_W-1:0];
   endfunction

endpackage

// File: rtl/seq_assert_chan.sv
// One checker channel: IDLE/WAIT FSM with window timer and registered match/fail pulses.
// match_nxt/fail_nxt expose the pulse values about to be registered so the top can count them in the same edge.
module seq_assert_chan
   import seq_assert_pkg::*;
#(
   parameter int WINDOW = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   input  logic trigger_in,
   input  logic signal_in,
   output logic match,
   output logic fail,
   output logic match_nxt,
   output logic fail_nxt
);

   localparam int TMR_W = $clog2(WINDOW + 1);

   chan_state_t      state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      match_nxt = 1'b0;
      fail_nxt  = 1'b0;
      if (clear || !enable) begin
         state_nxt = IDLE;
         timer_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (trigger_in) begin
                  if (signal_in) begin
                     match_nxt = 1'b1;
                  end else begin
                     state_nxt = WAIT;
                     timer_nxt = TMR_W'(1);
                  end
               end
            end
            WAIT: begin
               // triggers are deliberately ignored here: no overlap, no re-arm
               if (signal_in) begin
                  match_nxt = 1'b1;
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else if (timer == TMR_W'(WINDOW)) begin
                  fail_nxt  = 1'b1;
                  state_nxt = IDLE;
                  timer_nxt = '0;
               end else begin
                  timer_nxt = timer + TMR_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               timer_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
         match <= 1'b0;
         fail  <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         match <= match_nxt;
         fail  <= fail_nxt;
      end
   end

endmodule

// File: rtl/seq_assertion_checker.sv
// Multi-channel "trigger implies signal within WINDOW cycles" monitor with sticky flags and saturating counters.
// Optional first-fail capture enabled by defining SEQ_ASSERT_FIRST_FAIL_EN. NUM_CH and CNT_W must be <= 64.
module seq_assertion_checker
   import seq_assert_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int WINDOW = 8,
   parameter int CNT_W  = 16
`ifdef SEQ_ASSERT_FIRST_FAIL_EN
   , localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clear,
   input  logic [NUM_CH-1:0] trigger_in,
   input  logic [NUM_CH-1:0] signal_in,
   output logic [NUM_CH-1:0] match,
   output logic [NUM_CH-1:0] fail,
   output logic [NUM_CH-1:0] fail_sticky,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [CNT_W-1:0]  fail_cnt
`ifdef SEQ_ASSERT_FIRST_FAIL_EN
   ,
   output logic                first_fail_valid,
   output logic [CH_IDX_W-1:0] first_fail_ch
`endif
);

   logic [NUM_CH-1:0] match_nxt;
   logic [NUM_CH-1:0] fail_nxt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      seq_assert_chan #(.WINDOW(WINDOW)) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .enable    (enable),
         .clear     (clear),
         .trigger_in(trigger_in[g]),
         .signal_in (signal_in[g]),
         .match     (match[g]),
         .fail      (fail[g]),
         .match_nxt (match_nxt[g]),
         .fail_nxt  (fail_nxt[g])
      );
   end

   // Counters and sticky flags track the pulse values registered at the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_cnt   <= '0;
         fail_cnt    <= '0;
         fail_sticky <= '0;
      end else if (clear) begin
         match_cnt   <= '0;
         fail_cnt    <= '0;
         fail_sticky <= '0;
      end else begin
         match_cnt   <= CNT_W'(sat_add(POP_W'(match_cnt), popcount(POP_W'(match_nxt)), CNT_W));
         fail_cnt    <= CNT_W'(sat_add(POP_W'(fail_cnt), popcount(POP_W'(fail_nxt)), CNT_W));
         fail_sticky <= fail_sticky | fail_nxt;
      end
   end

`ifdef SEQ_ASSERT_FIRST_FAIL_EN
   logic [CH_IDX_W-1:0] ff_idx;

   always_comb begin
      ff_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (fail_nxt[i]) ff_idx = CH_IDX_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_valid <= 1'b0;
         first_fail_ch    <= '0;
      end else if (clear) begin
         first_fail_valid <= 1'b0;
         first_fail_ch    <= '0;
      end else if (!first_fail_valid && |fail_nxt) begin
         first_fail_valid <= 1'b1;
         first_fail_ch    <= ff_idx;
      end
   end
`endif

endmodule
